// File: rtl/gates_bist.sv
// Self-test sequencer for the eight-gate bank. Sweeps every {a,b} pair,
// holds each pair for SETTLE_CYC cycles, then compares all eight gate outputs
// against locally computed expectations. Collects a saturating count of
// failing vectors, a sticky per-gate fail mask and a pass/fail verdict.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start; results of the last sweep are held
// SETTLE | a_out/b_out applied, waiting for the bank outputs to settle
// CHECK  | one cycle; bank outputs are compared at the closing edge
// DONE   | one cycle; done pulse, verdict published, back to IDLE
module gates_bist #(
    parameter int WIDTH      = 4,
    parameter int SETTLE_CYC = 1,
    parameter int ERR_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    input  logic [WIDTH-1:0] y_and,
    input  logic [WIDTH-1:0] y_or,
    input  logic [WIDTH-1:0] y_nand,
    input  logic [WIDTH-1:0] y_nor,
    input  logic [WIDTH-1:0] y_xor,
    input  logic [WIDTH-1:0] y_xnor,
    input  logic [WIDTH-1:0] y_not,
    input  logic [WIDTH-1:0] y_buf,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [7:0]       fail_mask
);

    localparam int         IDX_W       = 2 * WIDTH;
    localparam logic [7:0] SETTLE_INIT = 8'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [7:0]       settle_cnt;
    logic [7:0]       mism;
    logic [ERR_W-1:0] err_next;
    logic [7:0]       mask_next;

    // The vector index register is the a/b drive; a is the upper half.
    assign a_out = idx[IDX_W-1:WIDTH];
    assign b_out = idx[WIDTH-1:0];

    // Per-gate mismatch against the currently applied vector; !== so that
    // undriven or unknown outputs are treated as failures.
    always_comb begin
        mism      = '0;
        mism[0]   = (y_and  !== (a_out & b_out));
        mism[1]   = (y_or   !== (a_out | b_out));
        mism[2]   = (y_nand !== ~(a_out & b_out));
        mism[3]   = (y_nor  !== ~(a_out | b_out));
        mism[4]   = (y_xor  !== (a_out ^ b_out));
        mism[5]   = (y_xnor !== ~(a_out ^ b_out));
        mism[6]   = (y_not  !== ~a_out);
        mism[7]   = (y_buf  !== a_out);
        mask_next = fail_mask | mism;
        err_next  = err_count;
        if ((mism != 8'h00) && (err_count != '1)) begin
            err_next = err_count + ERR_W'(1);
        end
    end

    // Sweep sequencer with registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            idx        <= '0;
            settle_cnt <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_mask  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state      <= S_SETTLE;
                        idx        <= '0;
                        settle_cnt <= SETTLE_INIT;
                        err_count  <= '0;
                        fail_mask  <= '0;
                        pass       <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt == '0) begin
                        state <= S_CHECK;
                    end else begin
                        settle_cnt <= settle_cnt - 8'd1;
                    end
                end
                S_CHECK: begin
                    err_count <= err_next;
                    fail_mask <= mask_next;
                    if (idx == '1) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next == '0) && (mask_next == 8'h00);
                    end else begin
                        idx        <= idx + IDX_W'(1);
                        settle_cnt <= SETTLE_INIT;
                        state      <= S_SETTLE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
